// File: rtl/i2c_byte3_master_pkg.sv
`default_nettype none
// i2c_byte3_master_pkg: state encoding, slot indices and pad-drive helper for the
// three-byte I2C write engine. Rev 1.0
package i2c_byte3_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BITS  = 3'd2,
    ST_STOP  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [4:0] ACK_SLOT_0 = 5'd8;
  localparam logic [4:0] ACK_SLOT_1 = 5'd17;
  localparam logic [4:0] ACK_SLOT_2 = 5'd26;
  localparam logic [4:0] BITS_LAST  = 5'd26;

  localparam logic [7:0] AUDIO_ADDR = 8'h34;
  localparam logic [7:0] VIDEO_ADDR = 8'h40;

  function automatic logic is_ack_slot(input logic [4:0] slot);
    return (slot == ACK_SLOT_0) || (slot == ACK_SLOT_1) || (slot == ACK_SLOT_2);
  endfunction

  // Returns {scl, sda_oe}; SDA only moves while SCL is low except START p1 / STOP p2.
  function automatic logic [1:0] pad_drive(input state_e st, input logic [1:0] phase,
                                           input logic dbit, input logic ack);
    logic [1:0] r;
    r = 2'b10;
    case (st)
      ST_START: r = (phase == 2'd0) ? 2'b10 : (phase == 2'd1) ? 2'b11 : 2'b01;
      ST_BITS:  r = {(phase == 2'd1) || (phase == 2'd2), ~ack & ~dbit};
      ST_STOP:  r = (phase == 2'd0) ? 2'b01 : (phase == 2'd1) ? 2'b11 : 2'b10;
      default:  r = 2'b10;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_byte3_master_if.sv
`default_nettype none
// i2c_byte3_master_if: sequencer handshake plus SCL/SDA pad signals. Rev 1.0
interface i2c_byte3_master_if;
  logic [23:0] i2c_data;
  logic        go;
  logic        ready;
  logic        mend;
  logic        mack;
  logic        i2c_sclk;
  logic        sda_oe;
  logic        sda_in;

  modport master (
    input  i2c_data, go, sda_in,
    output ready, mend, mack, i2c_sclk, sda_oe
  );

  modport slave (
    output i2c_data, go, sda_in,
    input  ready, mend, mack, i2c_sclk, sda_oe
  );
endinterface
`default_nettype wire

// File: rtl/i2c_byte3_master_phase_gen.sv
`default_nettype none
// i2c_byte3_master_phase_gen: CLK_DIV divider feeding a 2-bit quarter-bit phase counter.
// Rev 1.0
module i2c_byte3_master_phase_gen #(
  parameter int CLK_DIV = 125
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       en_i,
  input  wire logic       clr_i,
  output logic            tick_o,
  output logic            first_o,
  output logic [1:0]      phase_o
);

  localparam int             DW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic [1:0]    phase_q;

  assign tick_o  = en_i && (div_q == DIV_LAST);
  assign first_o = (div_q == '0);
  assign phase_o = phase_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      phase_q <= 2'd0;
    end else if (clr_i) begin
      div_q   <= '0;
      phase_q <= 2'd0;
    end else if (en_i) begin
      if (div_q == DIV_LAST) begin
        div_q   <= '0;
        phase_q <= phase_q + 2'd1;
      end else begin
        div_q   <= div_q + DW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_byte3_master.sv
`default_nettype none
// i2c_byte3_master: serialises one {slave, reg, data} word as START, 3 bytes + ACK, STOP.
// Rev 1.0
module i2c_byte3_master
  import i2c_byte3_master_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  wire logic          clk,
  input  wire logic          reset,
  i2c_byte3_master_if.master bus
);

  state_e      state_q;
  logic [23:0] shift_q;
  logic [4:0]  bit_cnt_q;
  logic        ack_err_q;
  logic        ready_q;
  logic        mend_q;
  logic        mack_q;
  logic        scl_q;
  logic        sda_oe_q;

  logic        ph_en;
  logic        ph_tick;
  logic        ph_first;
  logic [1:0]  ph_phase;
  logic        in_ack;
  logic        slot_end;

  assign ph_en    = (state_q == ST_START) || (state_q == ST_BITS) || (state_q == ST_STOP);
  assign in_ack   = is_ack_slot(bit_cnt_q);
  assign slot_end = ph_tick && (ph_phase == 2'd3);

  i2c_byte3_master_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase_gen (
    .clk     (clk),
    .reset   (reset),
    .en_i    (ph_en),
    .clr_i   (~ph_en),
    .tick_o  (ph_tick),
    .first_o (ph_first),
    .phase_o (ph_phase)
  );

  // Pads are registered from the current state/phase, so the bus trails the FSM by one clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ack_err_q <= 1'b0;
      ready_q   <= 1'b1;
      mend_q    <= 1'b0;
      mack_q    <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
    end else begin
      {scl_q, sda_oe_q} <= pad_drive(state_q, ph_phase, shift_q[23], in_ack);
      case (state_q)
        ST_IDLE: begin
          if (bus.go) begin
            shift_q   <= bus.i2c_data;
            bit_cnt_q <= '0;
            ack_err_q <= 1'b0;
            ready_q   <= 1'b0;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (slot_end) state_q <= ST_BITS;
        end
        ST_BITS: begin
          if (in_ack && ph_first && (ph_phase == 2'd2) && bus.sda_in) ack_err_q <= 1'b1;
          if (slot_end) begin
            if (!in_ack) shift_q <= {shift_q[22:0], 1'b0};
            if (bit_cnt_q == BITS_LAST) state_q <= ST_STOP;
            else                        bit_cnt_q <= bit_cnt_q + 5'd1;
          end
        end
        ST_STOP: begin
          if (slot_end) state_q <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE clk raises mend unconditionally, giving at least a 1-clk pulse.
          if (!mend_q) begin
            mend_q <= 1'b1;
            mack_q <= ~ack_err_q;
          end else if (!bus.go) begin
            mend_q  <= 1'b0;
            mack_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready    = ready_q;
  assign bus.mend     = mend_q;
  assign bus.mack     = mack_q;
  assign bus.i2c_sclk = scl_q;
  assign bus.sda_oe   = sda_oe_q;

endmodule
`default_nettype wire
